mux8_rr_arbiter: RTL

Round-robin arbiter that shares one 8:1 multiplexer between up to N_REQ requesters. It samples the request vector and grants exactly one requester at a time. It drives the mux select S and a one-hot grant, and holds the grant until the owner drops its request. A mandatory idle cycle between owners keeps mux switching glitch-free for downstream registered logic.

---
 rtl/mux8_rr_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning one 8:1 mux select, with a dead cycle between owners.
// Optional MUX_ARB_HOLD_LIMIT_EN forces release after MAX_HOLD grant cycles.
module mux8_rr_arbiter #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [SEL_W-1:0] S,
  output logic             VALID,
  output logic             TIMEOUT
);

  if (N_REQ < 2 || N_REQ > 8 || SEL_W != $clog2(N_REQ) || MAX_HOLD < 1 || MAX_HOLD > 255)
    begin : g_param_check
      $error("mux8_rr_arbiter: illegal parameter combination");
    end

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_REQ - 1);
  localparam logic [SEL_W:0]   NREQ_W = (SEL_W + 1)'(N_REQ);

  state_t           state, state_n;
  logic [N_REQ-1:0] gnt_q, gnt_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [SEL_W-1:0] ptr_q, ptr_n;
  logic [N_REQ-1:0] rot;
  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] pick;
  logic             found;
  logic             tout_n;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_n;
  logic       tout_q;
`endif

  // Rotate REQ so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    rot   = N_REQ'({REQ, REQ} >> ptr_q);
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (SEL_W + 1)'(i);
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        pick  = sum[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    ptr_n   = ptr_q;
    tout_n  = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    cnt_n   = cnt_q;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = N_REQ'(1) << pick;
          sel_n   = pick;
`ifdef MUX_ARB_HOLD_LIMIT_EN
          cnt_n   = '0;
`endif
        end
      end
      GRANT: begin
        if (!REQ[sel_q]) begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = (sel_q == LAST) ? '0 : sel_q + 1'b1;
        end
`ifdef MUX_ARB_HOLD_LIMIT_EN
        else if (cnt_q == HOLD_LAST) begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = (sel_q == LAST) ? '0 : sel_q + 1'b1;
          tout_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      cnt_q  <= '0;
      tout_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      gnt_q <= gnt_n;
      sel_q <= sel_n;
      ptr_q <= ptr_n;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      cnt_q  <= cnt_n;
      tout_q <= tout_n;
`endif
    end
  end

  assign GNT   = gnt_q;
  assign S     = sel_q;
  assign VALID = (state == GRANT);
`ifdef MUX_ARB_HOLD_LIMIT_EN
  assign TIMEOUT = tout_q;
`else
  assign TIMEOUT = 1'b0;
  logic unused_tout;
  assign unused_tout = tout_n;
`endif

endmodule
